clock_period_meter: RTL and testbench

Receive-side companion to the clock modulator: samples a divided/modulated clock signal in the system `clk` domain and recovers its period and high time as cycle counts. It sits downstream of the modulator output (or an external pin) and reports a per-period measurement strobe, a lock flag once the waveform is stable, and a timeout flag when the input stops toggling. Used by benches and on-board self-check to confirm the programmed division ratio.

---
 rtl/clock_period_meter.sv | 170 +++++++++++++++++
 tb/tb_clock_period_meter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
`default_nettype none
//==============================================================================
// Module      : clock_period_meter
// Description : Measures the period and high time of a slow, asynchronous
//               clock-like input (sig_in) as counts of the system clock.
//               A measurement is produced on every detected rising edge of
//               sig_in after the first one. The block also provides a lock
//               flag for a stable period and a timeout flag when the input
//               stops toggling.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               sig_in    - signal under measurement (asynchronous to clk)
//               period    - clk cycles between the last two rising edges
//               high_time - clk cycles sig_in was sampled high in that period
//               valid     - one-cycle strobe, period/high_time updated
//               locked    - two consecutive measured periods were equal
//               timeout   - no rising edge for 2^WIDTH-1 cycles
// Revision    : 1.0 - initial release
//==============================================================================
module clock_period_meter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             s3_q, s3_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_time_q, high_time_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;
   // Set once a measurement has been reported since the last IDLE; a lock
   // decision needs a previous period to compare against.
   logic             have_q, have_d;

   logic             edge_w;
   logic             cnt_sat_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
         have_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         cnt_q       <= cnt_d;
         hcnt_q      <= hcnt_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
         have_q      <= have_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      timeout_d   = timeout_q;
      have_d      = have_q;

      // Two-flop synchronizer plus one delay stage for edge detection.
      s1_d      = sig_in;
      s2_d      = s1_q;
      s3_d      = s2_q;
      edge_w    = s2_q & ~s3_q;
      cnt_sat_w = (cnt_q == CNT_MAX);

      // Both counters restart at 1 on the edge cycle: that cycle is the
      // first cycle of the new period and s2 is high in it.
      if (edge_w) begin
         cnt_d = CNT_ONE;
      end else if (!cnt_sat_w) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end

      if (edge_w) begin
         hcnt_d = CNT_ONE;
      end else if (s2_q && (hcnt_q != CNT_MAX)) begin
         hcnt_d = hcnt_q + CNT_ONE;
      end else begin
         hcnt_d = hcnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (edge_w) begin
               state_d   = ST_MEASURE;
               timeout_d = 1'b0;
            end
         end
         ST_MEASURE, ST_LOCKED: begin
            // A saturated count takes precedence over a coincident edge so
            // that a saturated value is never reported as a period.
            if (cnt_sat_w) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               have_d    = 1'b0;
            end else if (edge_w) begin
               period_d    = cnt_q;
               high_time_d = hcnt_q;
               valid_d     = 1'b1;
               have_d      = 1'b1;
               if (state_q == ST_MEASURE) begin
                  if (have_q && (cnt_q == period_q)) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else if (cnt_q != period_q) begin
                  state_d  = ST_MEASURE;
                  locked_d = 1'b0;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            have_d   = 1'b0;
         end
      endcase
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign locked    = locked_q;
   assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
//==============================================================================
// Module      : tb_clock_period_meter
// Description : Directed self-checking bench for clock_period_meter (WIDTH=8).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_clock_period_meter;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         sig_in;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         locked;
   logic         timeout;

   int nvec = 0;
   int nerr = 0;

   // Captured by the monitor on every valid strobe.
   int           vcnt = 0;
   logic [W-1:0] lp = '0;
   logic [W-1:0] lh = '0;
   logic         ll = 1'b0;
   logic         prev_valid = 1'b0;
   int           dbl = 0;

   clock_period_meter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (valid) begin
         vcnt++;
         lp = period;
         lh = high_time;
         ll = locked;
         if (prev_valid) dbl++;
      end
      prev_valid = valid;
   end

   // Called at a negedge: drive v and hold it for n clk cycles.
   task automatic hold(input logic v, input int n);
      sig_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int hi, input int lo, input int nper);
      for (int i = 0; i < nper; i++) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      sig_in = 1'b0;
      repeat (3) @(negedge clk);
      if (period    !== 8'd0) begin nerr++; $display("FAIL reset_period got=%0d exp=0", period); end nvec++;
      if (high_time !== 8'd0) begin nerr++; $display("FAIL reset_high got=%0d exp=0", high_time); end nvec++;
      if (valid     !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", valid); end nvec++;
      if (locked    !== 1'b0) begin nerr++; $display("FAIL reset_locked got=%b exp=0", locked); end nvec++;
      if (timeout   !== 1'b0) begin nerr++; $display("FAIL reset_timeout got=%b exp=0", timeout); end nvec++;
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_period8();
      int base;
      base = vcnt;
      wave(4, 4, 1);
      if (vcnt - base !== 0) begin nerr++; $display("FAIL p8_first_edge valids got=%0d exp=0", vcnt - base); end nvec++;
      wave(4, 4, 1);
      if (vcnt - base !== 1) begin nerr++; $display("FAIL p8_first_valid count got=%0d exp=1", vcnt - base); end nvec++;
      if (lp !== 8'd8) begin nerr++; $display("FAIL p8_first_period got=%0d exp=8", lp); end nvec++;
      if (lh !== 8'd4) begin nerr++; $display("FAIL p8_first_high got=%0d exp=4", lh); end nvec++;
      if (ll !== 1'b0) begin nerr++; $display("FAIL p8_first_locked got=%b exp=0", ll); end nvec++;
      wave(4, 4, 2);
      if (vcnt - base !== 3) begin nerr++; $display("FAIL p8_count got=%0d exp=3", vcnt - base); end nvec++;
      if (lp !== 8'd8) begin nerr++; $display("FAIL p8_period got=%0d exp=8", lp); end nvec++;
      if (ll !== 1'b1) begin nerr++; $display("FAIL p8_locked got=%b exp=1", ll); end nvec++;
   endtask

   task automatic test_duty35();
      int base;
      base = vcnt;
      wave(3, 5, 3);
      if (vcnt - base !== 3) begin nerr++; $display("FAIL duty_count got=%0d exp=3", vcnt - base); end nvec++;
      if (lp !== 8'd8) begin nerr++; $display("FAIL duty_period got=%0d exp=8", lp); end nvec++;
      if (lh !== 8'd3) begin nerr++; $display("FAIL duty_high got=%0d exp=3", lh); end nvec++;
      if (ll !== 1'b1) begin nerr++; $display("FAIL duty_locked got=%b exp=1", ll); end nvec++;
   endtask

   task automatic test_change();
      wave(6, 6, 1);
      if (lp !== 8'd8) begin nerr++; $display("FAIL chg_old_period got=%0d exp=8", lp); end nvec++;
      wave(6, 6, 1);
      if (lp !== 8'd12) begin nerr++; $display("FAIL chg_first_period got=%0d exp=12", lp); end nvec++;
      if (lh !== 8'd6) begin nerr++; $display("FAIL chg_first_high got=%0d exp=6", lh); end nvec++;
      if (ll !== 1'b0) begin nerr++; $display("FAIL chg_first_locked got=%b exp=0", ll); end nvec++;
      wave(6, 6, 1);
      if (lp !== 8'd12) begin nerr++; $display("FAIL chg_second_period got=%0d exp=12", lp); end nvec++;
      if (ll !== 1'b1) begin nerr++; $display("FAIL chg_second_locked got=%b exp=1", ll); end nvec++;
      // Back to 8: the 12-cycle period is reported once more, then 8 unlocks, then 8 relocks.
      wave(4, 4, 3);
      if (lp !== 8'd8) begin nerr++; $display("FAIL chg_back_period got=%0d exp=8", lp); end nvec++;
      if (ll !== 1'b1) begin nerr++; $display("FAIL chg_back_locked got=%b exp=1", ll); end nvec++;
   endtask

   task automatic test_timeout();
      int base;
      hold(1'b0, 200);
      if (timeout !== 1'b0) begin nerr++; $display("FAIL to_early timeout got=%b exp=0", timeout); end nvec++;
      if (locked  !== 1'b1) begin nerr++; $display("FAIL to_early locked got=%b exp=1", locked); end nvec++;
      hold(1'b0, 60);
      if (timeout   !== 1'b1) begin nerr++; $display("FAIL to_flag got=%b exp=1", timeout); end nvec++;
      if (locked    !== 1'b0) begin nerr++; $display("FAIL to_locked got=%b exp=0", locked); end nvec++;
      if (period    !== 8'd8) begin nerr++; $display("FAIL to_period_hold got=%0d exp=8", period); end nvec++;
      if (high_time !== 8'd4) begin nerr++; $display("FAIL to_high_hold got=%0d exp=4", high_time); end nvec++;
      base = vcnt;
      wave(4, 4, 1);
      if (timeout !== 1'b0) begin nerr++; $display("FAIL to_clear got=%b exp=0", timeout); end nvec++;
      if (vcnt - base !== 0) begin nerr++; $display("FAIL to_restart_first valids got=%0d exp=0", vcnt - base); end nvec++;
      wave(4, 4, 1);
      if (vcnt - base !== 1) begin nerr++; $display("FAIL to_restart_valid count got=%0d exp=1", vcnt - base); end nvec++;
      if (lp !== 8'd8) begin nerr++; $display("FAIL to_restart_period got=%0d exp=8", lp); end nvec++;
      if (ll !== 1'b0) begin nerr++; $display("FAIL to_restart_locked got=%b exp=0", ll); end nvec++;
   endtask

   task automatic test_reset_mid();
      int base;
      wave(4, 4, 2);
      if (locked !== 1'b1) begin nerr++; $display("FAIL rm_pre_locked got=%b exp=1", locked); end nvec++;
      hold(1'b1, 2);
      rst = 1'b1;
      @(negedge clk);
      if (period    !== 8'd0) begin nerr++; $display("FAIL rm_period got=%0d exp=0", period); end nvec++;
      if (high_time !== 8'd0) begin nerr++; $display("FAIL rm_high got=%0d exp=0", high_time); end nvec++;
      if (valid     !== 1'b0) begin nerr++; $display("FAIL rm_valid got=%b exp=0", valid); end nvec++;
      if (locked    !== 1'b0) begin nerr++; $display("FAIL rm_locked got=%b exp=0", locked); end nvec++;
      if (timeout   !== 1'b0) begin nerr++; $display("FAIL rm_timeout got=%b exp=0", timeout); end nvec++;
      rst  = 1'b0;
      base = vcnt;
      // sig_in is still high: that counts as the first post-reset edge.
      hold(1'b1, 2);
      hold(1'b0, 4);
      if (vcnt - base !== 0) begin nerr++; $display("FAIL rm_first_edge valids got=%0d exp=0", vcnt - base); end nvec++;
      wave(4, 4, 1);
      if (vcnt - base !== 1) begin nerr++; $display("FAIL rm_second_edge count got=%0d exp=1", vcnt - base); end nvec++;
      if (lp !== 8'd6) begin nerr++; $display("FAIL rm_period got=%0d exp=6", lp); end nvec++;
      if (lh !== 8'd2) begin nerr++; $display("FAIL rm_high got=%0d exp=2", lh); end nvec++;
      if (ll !== 1'b0) begin nerr++; $display("FAIL rm_locked_after got=%b exp=0", ll); end nvec++;
   endtask

   task automatic test_min_period();
      int base;
      base = vcnt;
      wave(1, 1, 8);
      hold(1'b0, 4);
      if (vcnt - base !== 8) begin nerr++; $display("FAIL min_count got=%0d exp=8", vcnt - base); end nvec++;
      if (lp !== 8'd2) begin nerr++; $display("FAIL min_period got=%0d exp=2", lp); end nvec++;
      if (lh !== 8'd1) begin nerr++; $display("FAIL min_high got=%0d exp=1", lh); end nvec++;
      if (ll !== 1'b1) begin nerr++; $display("FAIL min_locked got=%b exp=1", ll); end nvec++;
   endtask

   task automatic test_back_to_back();
      if (dbl !== 0) begin nerr++; $display("FAIL valid_back_to_back got=%0d exp=0", dbl); end nvec++;
   endtask

   initial begin
      rst    = 1'b1;
      sig_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_period8();
      test_duty35();
      test_change();
      test_timeout();
      test_reset_mid();
      test_min_period();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
